// File: rtl/dil_mem_pkg.sv
// Shared constants and reader state encoding for the coefficient memory
// and the streaming front ends that sit on top of it.
package dil_mem_pkg;

  localparam int ADDR_W = 16;
  localparam int DATA_W = 24;
  localparam int LEN_W  = 9;
  localparam int N_COEF = 256;
  localparam int DIL_Q  = 8380417;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2,
    FIN   = 2'd3
  } rd_state_e;

endpackage

// File: rtl/stream_fifo2.sv
// Two-entry registered FIFO used as the reader's output skid buffer.
// Head entry is read straight from a register, so pop_data_o is glitch-free.
module stream_fifo2 #(
  parameter int W = 25
) (
  input  logic         clk_i,
  input  logic         rst_ni,
  input  logic         push_i,
  input  logic [W-1:0] push_data_i,
  input  logic         pop_i,
  output logic [W-1:0] pop_data_o,
  output logic         full_o,
  output logic         empty_o,
  output logic [1:0]   count_o
);

  logic [W-1:0] mem_q [0:1];
  logic         wr_ptr_q;
  logic         rd_ptr_q;
  logic [1:0]   count_q;
  logic [1:0]   count_d;
  logic         do_push;
  logic         do_pop;

  assign full_o     = (count_q == 2'd2);
  assign empty_o    = (count_q == 2'd0);
  assign count_o    = count_q;
  assign pop_data_o = mem_q[rd_ptr_q];

  // A push into a full FIFO is accepted only when the head leaves this cycle.
  assign do_pop  = pop_i && !empty_o;
  assign do_push = push_i && (!full_o || do_pop);

  always_comb begin
    count_d = count_q;
    case ({do_push, do_pop})
      2'b10:   count_d = count_q + 2'd1;
      2'b01:   count_d = count_q - 2'd1;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int i = 0; i < 2; i++) begin
        mem_q[i] <= '0;
      end
      wr_ptr_q <= 1'b0;
      rd_ptr_q <= 1'b0;
      count_q  <= 2'd0;
    end else begin
      if (do_push) begin
        mem_q[wr_ptr_q] <= push_data_i;
        wr_ptr_q        <= ~wr_ptr_q;
      end
      if (do_pop) begin
        rd_ptr_q <= ~rd_ptr_q;
      end
      count_q <= count_d;
    end
  end

endmodule

// File: rtl/poly_mem_reader.sv
// Streams a run of coefficients out of memory port 0 as a valid/ready stream,
// hiding the one-cycle read latency and consumer stalls behind a 2-entry buffer.
module poly_mem_reader #(
  parameter int ADDR_W = dil_mem_pkg::ADDR_W,
  parameter int DATA_W = dil_mem_pkg::DATA_W,
  parameter int LEN_W  = dil_mem_pkg::LEN_W
) (
  input  logic              CLK,
  input  logic              RST_N,
  input  logic              start,
  input  logic [ADDR_W-1:0] base_addr,
  input  logic [LEN_W-1:0]  len,
  output logic              busy,
  output logic              done,
  output logic [ADDR_W-1:0] A0,
  output logic              CEB0,
  output logic              WEB0,
  output logic [DATA_W-1:0] BWEB0,
  output logic [DATA_W-1:0] D0,
  input  logic [DATA_W-1:0] Q0,
  output logic [DATA_W-1:0] out_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              out_last
);
  import dil_mem_pkg::*;

  rd_state_e         state_q;
  rd_state_e         state_d;
  logic [ADDR_W-1:0] base_q;
  logic [LEN_W-1:0]  len_q;
  logic [LEN_W-1:0]  issued_q;
  logic              inflight_q;
  logic              inflight_last_q;
  logic [ADDR_W-1:0] a0_q;

  logic              fifo_full;
  logic              fifo_empty;
  logic [1:0]        fifo_count;
  logic [DATA_W:0]   fifo_head;
  logic              pop;
  logic [2:0]        occ;
  logic              room;
  logic              issue;
  logic              last_issue;

  assign WEB0  = 1'b1;
  assign BWEB0 = '1;
  assign D0    = '0;

  assign out_valid = !fifo_empty;
  assign out_data  = fifo_head[DATA_W-1:0];
  assign out_last  = out_valid && fifo_head[DATA_W];
  assign pop       = out_valid && out_ready;

  // Words held plus the one in flight, less the one leaving, must stay below two.
  assign occ = 3'(fifo_count) + 3'(inflight_q);
  always_comb begin
    room = 1'b0;
    if (fifo_full) begin
      room = pop;
    end else begin
      room = (occ < 3'd2) || pop;
    end
  end

  assign issue      = (state_q == RUN) && (issued_q != len_q) && room;
  assign last_issue = (issued_q == len_q - LEN_W'(1));
  assign CEB0       = !issue;
  assign A0         = issue ? (base_q + ADDR_W'(issued_q)) : a0_q;

  stream_fifo2 #(
    .W (DATA_W + 1)
  ) u_out_buf (
    .clk_i       (CLK),
    .rst_ni      (RST_N),
    .push_i      (inflight_q),
    .push_data_i ({inflight_last_q, Q0}),
    .pop_i       (pop),
    .pop_data_o  (fifo_head),
    .full_o      (fifo_full),
    .empty_o     (fifo_empty),
    .count_o     (fifo_count)
  );

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    busy    = 1'b0;
    done    = 1'b0;
    case (state_q)
      IDLE: begin
        if (start) begin
          state_d = (len == '0) ? FIN : RUN;
        end
      end
      RUN: begin
        busy = 1'b1;
        if (issued_q == len_q) begin
          state_d = DRAIN;
        end
      end
      DRAIN: begin
        busy = 1'b1;
        // Leave once this cycle's pop empties the buffer, so FIN follows the last beat.
        if (!inflight_q && ((fifo_count == 2'd0) || ((fifo_count == 2'd1) && pop))) begin
          state_d = FIN;
        end
      end
      FIN: begin
        busy    = 1'b1;
        done    = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      base_q          <= '0;
      len_q           <= '0;
      issued_q        <= '0;
      inflight_q      <= 1'b0;
      inflight_last_q <= 1'b0;
      a0_q            <= '0;
    end else begin
      if ((state_q == IDLE) && start) begin
        base_q   <= base_addr;
        len_q    <= len;
        issued_q <= '0;
      end
      if (issue) begin
        issued_q <= issued_q + LEN_W'(1);
        a0_q     <= A0;
      end
      inflight_q      <= issue;
      inflight_last_q <= issue && last_issue;
    end
  end

endmodule

// File: tb/tb_poly_mem_reader.sv
// Directed bench for poly_mem_reader with a registered-read memory model.
module tb_poly_mem_reader;

  logic        CLK = 1'b0;
  logic        RST_N = 1'b1;
  logic        start = 1'b0;
  logic [15:0] base_addr = '0;
  logic [8:0]  len = '0;
  logic        busy, done, CEB0, WEB0, out_valid, out_last;
  logic [15:0] A0;
  logic [23:0] BWEB0, D0, out_data;
  logic [23:0] Q0 = '0;
  logic        out_ready = 1'b0;

  logic [23:0] mem [0:65535];
  logic [31:0] pat = 32'hB06E0DA7;
  int vectors = 0;
  int miscompares = 0;

  poly_mem_reader dut (
    .CLK       (CLK),
    .RST_N     (RST_N),
    .start     (start),
    .base_addr (base_addr),
    .len       (len),
    .busy      (busy),
    .done      (done),
    .A0        (A0),
    .CEB0      (CEB0),
    .WEB0      (WEB0),
    .BWEB0     (BWEB0),
    .D0        (D0),
    .Q0        (Q0),
    .out_data  (out_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_last  (out_last)
  );

  always #5 CLK = ~CLK;

  // Registered read; anything but the cycle after an issue returns junk.
  always @(posedge CLK) Q0 <= (!CEB0) ? mem[A0] : 24'hBADBAD;

  function automatic logic [23:0] coef(input logic [15:0] a);
    return 24'((32'(a) * 3) % 8380417);
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    vectors++;
    assert (obs === expv) else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  task automatic start_xfer(input logic [15:0] b, input logic [8:0] n);
    base_addr = b;
    len       = n;
    start     = 1'b1;
    @(posedge CLK);
    #1;
    start = 1'b0;
  endtask

  // mode 0: always ready, exact latency checked; mode 1: stall pattern.
  task automatic run_xfer(input logic [15:0] b, input int n, input int mode, input int spur);
    int issues, beats, last_hs;
    logic pv, pl;
    logic [23:0] pd;
    bit fin;
    issues = 0; beats = 0; last_hs = 0; pv = 1'b0; pl = 1'b0; pd = '0; fin = 1'b0;
    for (int cyc = 1; cyc <= 600 && !fin; cyc++) begin
      out_ready = (mode == 0) ? 1'b1 : pat[cyc % 32];
      if (cyc == spur) begin
        start = 1'b1; base_addr = 16'h5000; len = 9'd3;
      end else begin
        start = 1'b0;
      end
      #1;
      if (!CEB0) begin
        chk("addr", 32'(A0), 32'(16'(b + 16'(issues))));
        if (mode == 0) chk("issue_cyc", cyc, issues + 1);
        issues++;
      end
      if (pv) begin
        chk("stall_valid", 32'(out_valid), 1);
        chk("stall_data", 32'(out_data), 32'(pd));
        chk("stall_last", 32'(out_last), 32'(pl));
      end
      pv = out_valid && !out_ready;
      pd = out_data;
      pl = out_last;
      if (out_valid && out_ready) begin
        chk("data", 32'(out_data), 32'(coef(16'(b + 16'(beats)))));
        chk("last", 32'(out_last), 32'(beats == n - 1));
        if (mode == 0) chk("beat_cyc", cyc, beats + 3);
        beats++;
        last_hs = cyc;
      end
      chk("occupancy", 32'(issues - beats <= 2), 1);
      chk("busy", 32'(busy), 1);
      if (done) begin
        chk("done_cyc", cyc, last_hs + 1);
        chk("beats", beats, n);
        chk("issues", issues, n);
        fin = 1'b1;
      end else begin
        @(posedge CLK);
        #1;
      end
    end
    if (!fin) chk("timeout", 0, 1);
    start = 1'b0;
    @(posedge CLK);
    #1;
    #1;
    chk("busy_after", 32'(busy), 0);
    chk("done_after", 32'(done), 0);
    chk("ceb_after", 32'(CEB0), 1);
  endtask

  initial begin
    for (int i = 0; i < 65536; i++) mem[i] = coef(16'(i));

    #1 RST_N = 1'b0;
    #1;
    chk("rst_busy", 32'(busy), 0);
    chk("rst_done", 32'(done), 0);
    chk("rst_valid", 32'(out_valid), 0);
    chk("rst_data", 32'(out_data), 0);
    chk("rst_last", 32'(out_last), 0);
    chk("rst_ceb", 32'(CEB0), 1);
    chk("rst_a0", 32'(A0), 0);
    chk("rst_web", 32'(WEB0), 1);
    chk("rst_bweb", 32'(BWEB0), 32'h00FF_FFFF);
    chk("rst_d0", 32'(D0), 0);
    @(posedge CLK);
    @(posedge CLK);
    #1 RST_N = 1'b1;
    @(posedge CLK);
    #1;

    start_xfer(16'h0100, 9'd256);
    run_xfer(16'h0100, 256, 0, 0);

    start_xfer(16'h0000, 9'd0);
    run_xfer(16'h0000, 0, 0, 0);

    start_xfer(16'h0040, 9'd16);
    run_xfer(16'h0040, 16, 1, 0);

    start_xfer(16'hFFFE, 9'd4);
    run_xfer(16'hFFFE, 4, 0, 0);

    start_xfer(16'h0300, 9'd16);
    run_xfer(16'h0300, 16, 0, 5);

    // Abort a long run after ten beats have been taken.
    out_ready = 1'b1;
    start_xfer(16'h0100, 9'd256);
    repeat (12) @(posedge CLK);
    #1 RST_N = 1'b0;
    #1;
    chk("abort_valid", 32'(out_valid), 0);
    chk("abort_ceb", 32'(CEB0), 1);
    chk("abort_busy", 32'(busy), 0);
    chk("abort_data", 32'(out_data), 0);
    @(posedge CLK);
    @(posedge CLK);
    #1 RST_N = 1'b1;
    for (int k = 0; k < 3; k++) begin
      @(posedge CLK);
      #1;
      chk("post_rst_valid", 32'(out_valid), 0);
      chk("post_rst_ceb", 32'(CEB0), 1);
      chk("post_rst_busy", 32'(busy), 0);
    end

    start_xfer(16'h0200, 9'd8);
    run_xfer(16'h0200, 8, 0, 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
